fetch_unit: RTL and testbench

- Instruction-fetch stage of the 8-bit core, directly upstream of the opcode decode ROM.
- Holds the program counter and issues req/ack reads to instruction memory.
- Latches the returned 16-bit word into an instruction register (IR) and presents `opcode` (IR[15:12]) to decode, with a valid/ready handshake.
- Accepts PC redirects from jump/branch writeback and squashes in-flight fetches.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC and reads instruction
// memory with a req/ack handshake. The returned word is latched into the IR
// and offered to decode with a valid/ready handshake. A redirect loads a new
// PC; a read already in flight is squashed and its data dropped.
// Optional build macro: FETCH_PERF_EN adds the perf_fetched/perf_wait counters.
module fetch_unit #(
   parameter int unsigned         PC_W     = 8,
   parameter logic [PC_W-1:0]     RESET_PC = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   imem_req,
   output logic [PC_W-1:0]        imem_addr,
   input  logic                   imem_ack,
   input  logic [15:0]            imem_data,
   output logic                   ir_valid,
   input  logic                   ir_ready,
   output logic [3:0]             opcode,
   output logic [11:0]            operand,
   output logic [PC_W-1:0]        ir_pc,
   input  logic                   redirect,
   input  logic [PC_W-1:0]        redirect_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]            perf_fetched,
   output logic [15:0]            perf_wait
`endif
);

   typedef enum logic [1:0] {START, FETCH, HOLD, DROP} state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [15:0]       ir_q, ir_d;
   logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
   logic [PC_W-1:0]   target_q, target_d;

   // State, PC, IR and squash-target registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= START;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         ir_pc_q  <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         ir_pc_q  <= ir_pc_d;
         target_q <= target_d;
      end
   end

   // Next-state logic: fetch, hold for decode, or drain a squashed read
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ir_pc_d  = ir_pc_q;
      target_d = target_q;
      unique case (state_q)
         START: begin
            if (redirect) pc_d = redirect_pc;
            state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_d = redirect_pc;
               end else begin
                  ir_d    = imem_data;
                  ir_pc_d = pc_q;
                  pc_d    = pc_q + PC_W'(1);
                  state_d = HOLD;
               end
            end else if (redirect) begin
               // Address must stay stable until ack, so park the target.
               target_d = redirect_pc;
               state_d  = DROP;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = FETCH;
            end else if (ir_ready) begin
               state_d = FETCH;
            end
         end
         DROP: begin
            if (imem_ack) begin
               // A redirect in the ack cycle is newer than the parked target.
               pc_d    = redirect ? redirect_pc : target_q;
               state_d = FETCH;
            end else if (redirect) begin
               target_d = redirect_pc;
            end
         end
         default: state_d = START;
      endcase
   end

   assign imem_req  = (state_q == FETCH) || (state_q == DROP);
   assign imem_addr = pc_q;
   assign ir_valid  = (state_q == HOLD);
   assign opcode    = ir_q[15:12];
   assign operand   = ir_q[11:0];
   assign ir_pc     = ir_pc_q;

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_q, perf_wait_q;

   // Saturating counters: instructions consumed and memory wait cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_wait_q    <= '0;
      end else begin
         if ((state_q == HOLD) && ir_ready && !redirect && (perf_fetched_q != '1))
            perf_fetched_q <= perf_fetched_q + 16'd1;
         if (imem_req && !imem_ack && (perf_wait_q != '1))
            perf_wait_q <= perf_wait_q + 16'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of the fetch stage compared
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = '0;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic [3:0]  opcode;
   logic [11:0] operand;
   logic [7:0]  ir_pc;
   logic        redirect = 1'b0;
   logic [7:0]  redirect_pc = '0;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_wait;
`endif

   int checks = 0;
   int errors = 0;

   fetch_unit #(.PC_W(8), .RESET_PC(8'h10)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .opcode(opcode), .operand(operand), .ir_pc(ir_pc),
      .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_wait(perf_wait)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory contents and responder with programmable wait cycles
   logic [15:0] mem [256];
   int          waits = 0;
   int          wcnt  = 0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'((i * 263) ^ 'h3C5A);
      mem[8'h10] = 16'hA123;
   end

   always @(posedge clk) begin
      #1;
      if (imem_req && !rst) begin
         if (wcnt >= waits) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
            wcnt      = 0;
         end else begin
            imem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end
   end

   // Transaction-level model: is a read outstanding, is it squashed, is an IR held
   bit          m_started = 0;
   bit          m_reading = 0;
   bit          m_squash  = 0;
   bit          m_have_ir = 0;
   logic [7:0]  m_pc      = 8'h10;
   logic [7:0]  m_tgt     = '0;
   logic [15:0] m_ir      = '0;
   logic [7:0]  m_irpc    = '0;
   int          m_fetched = 0;
   int          m_wait    = 0;
   bit          cmp_en    = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_started = 0; m_reading = 0; m_squash = 0; m_have_ir = 0;
         m_pc = 8'h10; m_tgt = '0; m_ir = '0; m_irpc = '0;
         m_fetched = 0; m_wait = 0;
         cmp_en = 1;
      end else if (!m_started) begin
         if (redirect) m_pc = redirect_pc;
         m_started = 1;
         m_reading = 1;
      end else if (m_have_ir) begin
         if (ir_ready && !redirect && m_fetched < 65535) m_fetched++;
         if (redirect) m_pc = redirect_pc;
         if (redirect || ir_ready) begin
            m_have_ir = 0;
            m_reading = 1;
         end
      end else begin
         if (!imem_ack && m_wait < 65535) m_wait++;
         if (imem_ack) begin
            if (m_squash) begin
               m_pc     = redirect ? redirect_pc : m_tgt;
               m_squash = 0;
            end else if (redirect) begin
               m_pc = redirect_pc;
            end else begin
               m_ir      = imem_data;
               m_irpc    = m_pc;
               m_pc      = 8'((int'(m_pc) + 1) % 256);
               m_reading = 0;
               m_have_ir = 1;
            end
         end else if (redirect) begin
            m_squash = 1;
            m_tgt    = redirect_pc;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_req",   imem_req,  m_reading);
         chk("m_addr",  imem_addr, m_pc);
         chk("m_valid", ir_valid,  m_have_ir);
         if (m_have_ir) begin
            chk("m_opcode",  opcode,  m_ir[15:12]);
            chk("m_operand", operand, m_ir[11:0]);
            chk("m_ir_pc",   ir_pc,   m_irpc);
         end
`ifdef FETCH_PERF_EN
         chk("m_perf_fetched", perf_fetched, m_fetched);
         chk("m_perf_wait",    perf_wait,    m_wait);
`endif
      end
   end

   task automatic do_reset(input int w, input logic rdy, input logic rd, input logic [7:0] rpc);
      rst = 1'b1; redirect = 1'b0; ir_ready = rdy; waits = w;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; redirect = rd; redirect_pc = rpc;
      @(posedge clk); #1;
      redirect = 1'b0;
   endtask

   task automatic wait_req();
      @(negedge clk);
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      chk("req_timeout", imem_req, 1'b1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req",   imem_req,  1'b0);
      chk("rst_addr",  imem_addr, 8'h10);
      chk("rst_valid", ir_valid,  1'b0);
      chk("rst_ir_pc", ir_pc,     8'h00);
      chk("rst_op",    {opcode, operand}, 16'h0000);

      // Zero-wait memory, ready held high
      do_reset(0, 1'b1, 1'b0, 8'h00);
      wait_req();
      chk("t1_addr", imem_addr, 8'h10);
      @(negedge clk);
      chk("t1_valid",   ir_valid, 1'b1);
      chk("t1_opcode",  opcode,   4'hA);
      chk("t1_operand", operand,  12'h123);
      chk("t1_ir_pc",   ir_pc,    8'h10);
      @(negedge clk);
      chk("t1_req2",  imem_req,  1'b1);
      chk("t1_addr2", imem_addr, 8'h11);

      // 3 wait cycles, decode stalls 4 cycles
      do_reset(3, 1'b0, 1'b0, 8'h00);
      wait_req();
      for (int i = 0; i < 4; i++) begin
         chk("t2_req_held",  imem_req,  1'b1);
         chk("t2_addr_held", imem_addr, 8'h10);
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         chk("t2_valid",  ir_valid, 1'b1);
         chk("t2_no_req", imem_req, 1'b0);
         chk("t2_ir",     {opcode, operand}, 16'hA123);
         @(negedge clk);
      end
      @(posedge clk); #1; ir_ready = 1'b1;
      @(negedge clk);
      chk("t2_valid_last", ir_valid, 1'b1);
      @(negedge clk);
      chk("t2_next_addr", imem_addr, 8'h11);
      chk("t2_next_req",  imem_req,  1'b1);
`ifdef FETCH_PERF_EN
      chk("t2_perf_wait",    perf_wait,    16'd3);
      chk("t2_perf_fetched", perf_fetched, 16'd1);
`endif

      // Redirect one cycle into a 3-wait fetch of 0x05
      do_reset(3, 1'b1, 1'b1, 8'h05);
      @(negedge clk);
      chk("t3_addr_c1", imem_addr, 8'h05);
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 8'h40;
      @(negedge clk);
      chk("t3_addr_c2", imem_addr, 8'h05);
      @(posedge clk); #1; redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t3_addr_held", imem_addr, 8'h05);
         chk("t3_req_held",  imem_req,  1'b1);
         chk("t3_no_valid",  ir_valid,  1'b0);
      end
      @(negedge clk);
      chk("t3_target_addr", imem_addr, 8'h40);
      chk("t3_target_req",  imem_req,  1'b1);
      chk("t3_no_valid2",   ir_valid,  1'b0);

      // Successive redirects while draining; the ack-cycle one wins
      do_reset(3, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 8'h77;
      @(posedge clk); #1; redirect_pc = 8'h20;
      @(posedge clk); #1; redirect_pc = 8'h30;
      @(posedge clk); #1; redirect = 1'b0;
      @(negedge clk);
      chk("t4_addr", imem_addr, 8'h30);
      chk("t4_req",  imem_req,  1'b1);

      // PC wrap at 0xFF
      do_reset(0, 1'b1, 1'b1, 8'hFF);
      @(negedge clk);
      chk("t5_addr_ff", imem_addr, 8'hFF);
      @(negedge clk);
      chk("t5_ir_pc", ir_pc, 8'hFF);
      @(negedge clk);
      chk("t5_wrap", imem_addr, 8'h00);

      // Redirect together with ready in HOLD
      do_reset(0, 1'b0, 1'b0, 8'h00);
      wait_req();
      @(posedge clk); #1; redirect = 1'b1; redirect_pc = 8'h55; ir_ready = 1'b1;
      @(negedge clk);
      chk("t6_valid", ir_valid, 1'b1);
      @(posedge clk); #1; redirect = 1'b0; ir_ready = 1'b0;
      @(negedge clk);
      chk("t6_valid_fall", ir_valid,  1'b0);
      chk("t6_addr",       imem_addr, 8'h55);
      chk("t6_req",        imem_req,  1'b1);
`ifdef FETCH_PERF_EN
      chk("t6_perf_fetched", perf_fetched, 16'd0);
      chk("t6_perf_wait",    perf_wait,    16'd0);
`endif

      // Mixed pattern of ready/redirect with one wait cycle, model-checked
      begin
         logic [47:0] rdy_pat = 48'hB6D5_A3C9_E1F7;
         logic [47:0] rd_pat  = 48'h0420_1084_2108;
         do_reset(1, 1'b1, 1'b0, 8'h00);
         for (int i = 0; i < 48; i++) begin
            @(posedge clk); #1;
            ir_ready    = rdy_pat[i];
            redirect    = rd_pat[i];
            redirect_pc = 8'(8'h80 + i);
         end
         @(posedge clk); #1; redirect = 1'b0; ir_ready = 1'b1;
         repeat (4) @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
